// File: rtl/mult_control_unit.sv
// Sequencer for a shift-and-add multiplier. The datapath (multiplier
// right-shifter, multiplicand left-shifter, accumulator) lives outside; this
// block loads the operands, steps through at most Word_Length iterations and
// pulses done when the accumulator holds the product.
//
//   state | meaning
//   IDLE  | waiting for start; outputs quiet, Iter_Count keeps last result
//   LOAD  | one cycle: operand shifters load, accumulator clears
//   RUN   | one iteration per cycle; add when current multiplier LSB is 1
//   DONE  | one cycle: product valid, done pulse
module mult_control_unit #(
  parameter int Word_Length = 8,
  localparam int CW = $clog2(Word_Length + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          Multiplier_LSB,
  input  logic          Multiplier_Zero,
  output logic          Load_enable,
  output logic          Acc_clear,
  output logic          Add_enable,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] Iter_Count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Terminal count: the iteration that runs with this count is the last one.
  localparam logic [CW-1:0] LAST_ITER = CW'(Word_Length - 1);

  state_t state, state_next;
  logic [CW-1:0] iter_q;

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Iteration counter: cleared when an operation is accepted, advanced on
  // every RUN cycle that does real work (not on the zero-detect exit cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_q <= '0;
    end else if ((state == IDLE && start) || state == LOAD) begin
      iter_q <= '0;
    end else if (state == RUN && !Multiplier_Zero) begin
      iter_q <= iter_q + CW'(1);
    end
  end

  assign Iter_Count = iter_q;

  // Next-state and output decode from the current state and datapath flags.
  always_comb begin
    state_next  = state;
    Load_enable = 1'b0;
    Acc_clear   = 1'b0;
    Add_enable  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        Load_enable = 1'b1;
        Acc_clear   = 1'b1;
        busy        = 1'b1;
        state_next  = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        Add_enable = Multiplier_LSB & ~Multiplier_Zero;
        // Zero multiplier means every remaining add would be zero: stop early.
        if (Multiplier_Zero || iter_q == LAST_ITER) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_control_unit.sv
// Bench for mult_control_unit: a behavioural shift-and-add datapath around the
// controller, with expected iteration counts and add patterns derived from the
// multiplier value arithmetically.
module tb_mult_control_unit;

  localparam int WL = 8;
  localparam int CW = $clog2(WL + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          Multiplier_LSB;
  logic          Multiplier_Zero;
  logic          Load_enable;
  logic          Acc_clear;
  logic          Add_enable;
  logic          busy;
  logic          done;
  logic [CW-1:0] Iter_Count;

  logic [WL-1:0]   op_mult;
  logic [WL-1:0]   op_mcand;
  logic [WL-1:0]   mreg;
  logic [2*WL-1:0] dreg;
  logic [2*WL-1:0] acc;

  int   errors = 0;
  int   checks = 0;
  logic prev_done = 1'b0;

  mult_control_unit #(.Word_Length(WL)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .Multiplier_LSB  (Multiplier_LSB),
    .Multiplier_Zero (Multiplier_Zero),
    .Load_enable     (Load_enable),
    .Acc_clear       (Acc_clear),
    .Add_enable      (Add_enable),
    .busy            (busy),
    .done            (done),
    .Iter_Count      (Iter_Count)
  );

  always #5 clk = ~clk;

  // Datapath model: operand shifters and accumulator driven by the controller.
  always @(posedge clk) begin
    if (Load_enable) begin
      mreg <= op_mult;
      dreg <= {{WL{1'b0}}, op_mcand};
    end else begin
      mreg <= mreg >> 1;
      dreg <= dreg << 1;
    end
    if (Acc_clear)       acc <= '0;
    else if (Add_enable) acc <= acc + dreg;
  end

  assign Multiplier_LSB  = mreg[0];
  assign Multiplier_Zero = (mreg == '0);

  function automatic int msb_pos(input logic [WL-1:0] m);
    for (int b = WL - 1; b >= 0; b--) if (m[b]) return b;
    return -1;
  endfunction

  // RUN cycles: a zero multiplier takes one; otherwise one per bit up to the
  // top set bit plus a zero-detect cycle, capped at WL.
  function automatic int exp_runs(input logic [WL-1:0] m);
    int h;
    h = msb_pos(m);
    if (h < 0) return 1;
    return (h == WL - 1) ? WL : h + 2;
  endfunction

  function automatic int exp_iters(input logic [WL-1:0] m);
    return msb_pos(m) + 1;
  endfunction

  function automatic logic exp_add(input logic [WL-1:0] m, input int i);
    int h;
    h = msb_pos(m);
    if (h < 0 || i > h + 1) return 1'b0;
    return m[i-1];
  endfunction

  // Advance one cycle, sample after the edge, and check per-cycle invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (Acc_clear && Add_enable) begin
      errors++;
      $display("FAIL excl_clear_add: Acc_clear=%0b Add_enable=%0b, required not both 1", Acc_clear, Add_enable);
    end
    checks++;
    if (Load_enable && Add_enable) begin
      errors++;
      $display("FAIL excl_load_add: Load_enable=%0b Add_enable=%0b, required not both 1", Load_enable, Add_enable);
    end
    checks++;
    if (done && prev_done) begin
      errors++;
      $display("FAIL done_twice: done high two cycles in a row, required single pulse");
    end
    checks++;
    if (done && busy) begin
      errors++;
      $display("FAIL busy_in_done: busy=%0b while done=1, required 0", busy);
    end
    prev_done = done;
  endtask

  // One complete operation from IDLE; returns observed RUN count and adds.
  task automatic run_op(input logic [WL-1:0] m, input logic [WL-1:0] d, input bit noisy,
                        output int n, output logic [WL-1:0] add_seq);
    int k;
    logic [2*WL-1:0] prod;
    k = exp_runs(m);
    prod = (2*WL)'(m) * (2*WL)'(d);
    add_seq = '0;
    op_mult = m;
    op_mcand = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({Load_enable, Acc_clear, busy, Add_enable, done} !== 5'b11100 || Iter_Count !== '0) begin
      errors++;
      $display("FAIL load_state: ld=%0b clr=%0b busy=%0b add=%0b done=%0b iter=%0d, required 1 1 1 0 0 iter=0",
               Load_enable, Acc_clear, busy, Add_enable, done, Iter_Count);
    end
    n = 0;
    for (int c = 0; c < WL + 2; c++) begin
      if (noisy) start = 1'($urandom_range(0, 1));
      tick();
      if (done) break;
      n++;
      checks++;
      if (busy !== 1'b1 || Load_enable !== 1'b0 || Acc_clear !== 1'b0 || Add_enable !== exp_add(m, n)) begin
        errors++;
        $display("FAIL run_outputs: m=%h cycle=%0d busy=%0b ld=%0b clr=%0b add=%0b, required 1 0 0 %0b",
                 m, n, busy, Load_enable, Acc_clear, Add_enable, exp_add(m, n));
      end
      checks++;
      if (Iter_Count !== CW'(n - 1)) begin
        errors++;
        $display("FAIL run_iter: m=%h cycle=%0d Iter_Count=%0d, required %0d", m, n, Iter_Count, n - 1);
      end
      if (n <= WL) add_seq[n-1] = Add_enable;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: m=%h no done within %0d cycles of LOAD", m, WL + 2);
    end
    checks++;
    if (n !== k) begin
      errors++;
      $display("FAIL run_count: m=%h RUN cycles=%0d (done at %0d after accept), required %0d (%0d)", m, n, n + 2, k, k + 2);
    end
    checks++;
    if (busy !== 1'b0 || Load_enable !== 1'b0 || Add_enable !== 1'b0 || Acc_clear !== 1'b0
        || Iter_Count !== CW'(exp_iters(m))) begin
      errors++;
      $display("FAIL done_state: m=%h busy=%0b ld=%0b add=%0b clr=%0b iter=%0d, required 0 0 0 0 iter=%0d",
               m, busy, Load_enable, Add_enable, Acc_clear, Iter_Count, exp_iters(m));
    end
    checks++;
    if (acc !== prod) begin
      errors++;
      $display("FAIL product: %h*%h accumulator=%h, required %h", m, d, acc, prod);
    end
    start = 1'b0;
    tick();
    checks++;
    if ({Load_enable, Acc_clear, Add_enable, busy, done} !== 5'b0 || Iter_Count !== CW'(exp_iters(m))) begin
      errors++;
      $display("FAIL idle_after: ld=%0b clr=%0b add=%0b busy=%0b done=%0b iter=%0d, required all 0 iter=%0d",
               Load_enable, Acc_clear, Add_enable, busy, done, Iter_Count, exp_iters(m));
    end
    tick();
    checks++;
    if (busy !== 1'b0 || Load_enable !== 1'b0) begin
      errors++;
      $display("FAIL no_queue: busy=%0b ld=%0b with start low in IDLE, required 0 0", busy, Load_enable);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    checks++;
    if ({Load_enable, Acc_clear, Add_enable, busy, done} !== 5'b0 || Iter_Count !== '0) begin
      errors++;
      $display("FAIL reset_state: ld=%0b clr=%0b add=%0b busy=%0b done=%0b iter=%0d, required all 0",
               Load_enable, Acc_clear, Add_enable, busy, done, Iter_Count);
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || Load_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%0b ld=%0b, required 0 0", busy, Load_enable);
    end
  endtask

  task automatic test_directed();
    int n;
    logic [WL-1:0] s;
    run_op(8'hA5, 8'h37, 1'b0, n, s);
    checks++;
    if (n !== 8 || s !== 8'hA5) begin
      errors++;
      $display("FAIL dir_a5: runs=%0d adds=%b, required runs=8 adds(first at bit0)=10100101", n, s);
    end
    run_op(8'h03, 8'hC9, 1'b0, n, s);
    checks++;
    if (n !== 3 || s !== 8'h03) begin
      errors++;
      $display("FAIL dir_03: runs=%0d adds=%b, required runs=3 adds=00000011", n, s);
    end
    run_op(8'h00, 8'hFF, 1'b0, n, s);
    checks++;
    if (n !== 1 || s !== 8'h00) begin
      errors++;
      $display("FAIL dir_00: runs=%0d adds=%b, required runs=1 adds=0", n, s);
    end
    run_op(8'h80, 8'hFF, 1'b1, n, s);
    checks++;
    if (n !== 8 || s !== 8'h80) begin
      errors++;
      $display("FAIL dir_80: runs=%0d adds=%b, required runs=8 adds=10000000", n, s);
    end
  endtask

  // Start held high: operations repeat every 11 cycles (LOAD, 8 RUN, DONE, IDLE).
  task automatic test_back_to_back();
    bit seen;
    int p;
    op_mult = 8'hFF;
    op_mcand = 8'h5A;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      p = (c - 1) % 11;
      checks++;
      if (busy !== (p <= 8) || done !== (p == 9) || Load_enable !== (p == 0)) begin
        errors++;
        $display("FAIL b2b_seq: cycle=%0d busy=%0b done=%0b ld=%0b, required %0b %0b %0b",
                 c, busy, done, Load_enable, p <= 8, p == 9, p == 0);
      end
      if (p == 9) begin
        checks++;
        if (Iter_Count !== CW'(8) || acc !== 16'(8'hFF * 8'h5A)) begin
          errors++;
          $display("FAIL b2b_result: cycle=%0d iter=%0d acc=%h, required 8 and %h", c, Iter_Count, acc, 16'(8'hFF * 8'h5A));
        end
      end
    end
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 15 && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_drain: done not seen within 15 cycles after start dropped");
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int n;
    logic [WL-1:0] s;
    bit saw_done;
    op_mult = 8'hC3;
    op_mcand = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1 || Iter_Count !== CW'(3)) begin
      errors++;
      $display("FAIL abort_pre: busy=%0b iter=%0d in 4th RUN cycle, required 1 and 3", busy, Iter_Count);
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if ({Load_enable, Acc_clear, Add_enable, busy, done} !== 5'b0 || Iter_Count !== '0) begin
      errors++;
      $display("FAIL abort_state: ld=%0b clr=%0b add=%0b busy=%0b done=%0b iter=%0d, required all 0",
               Load_enable, Acc_clear, Add_enable, busy, done, Iter_Count);
    end
    saw_done = 1'b0;
    repeat (12) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_quiet: done or busy seen after abort, required none");
    end
    run_op(8'hC3, 8'h11, 1'b0, n, s);
  endtask

  task automatic test_random();
    int n;
    logic [WL-1:0] s;
    logic [WL-1:0] m;
    for (int t = 0; t < 40; t++) begin
      m = WL'($urandom);
      if (t % 5 == 0) m = m >> $urandom_range(0, WL);
      run_op(m, WL'($urandom), 1'b1, n, s);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_mult = '0;
    op_mcand = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
